// File: rtl/yuv420_chroma_decimate_pkg.sv
// Shared dtype codes for the img_clk YUV pipeline.
package yuv420_chroma_decimate_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PXL         = 4'h0;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_START  = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_END    = 4'h4;

endpackage

// File: rtl/yuv420_chroma_decimate_chroma_line_buffer.sv
// Single-port synchronous RAM holding the even-row horizontal chroma sums.
// Read data is registered and held until the next read.
module yuv420_chroma_decimate_chroma_line_buffer #(
    parameter int DEPTH = 960,
    parameter int WIDTH = 22,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/yuv420_chroma_decimate.sv
// 4:4:4 -> 4:2:0 chroma decimation with 2-cycle fixed latency for all fields.
// Define YUV420_CHROMA_DECIMATE_SKIP_EN to pick the bottom-right sample instead of averaging.
module yuv420_chroma_decimate
    import yuv420_chroma_decimate_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_COLS    = 1920
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]  meta_datai,
    input  logic [PIXEL_WIDTH-1:0] yi,
    input  logic [PIXEL_WIDTH-1:0] ui,
    input  logic [PIXEL_WIDTH-1:0] vi,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]  meta_datao,
    output logic [PIXEL_WIDTH-1:0] yo,
    output logic [PIXEL_WIDTH-1:0] uo,
    output logic [PIXEL_WIDTH-1:0] vo,
    output logic                   chroma_dvo,
    output logic                   col_overflow
);

    localparam int COL_W = $clog2(MAX_COLS + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_COLS);

    // Frame/row tracking state
    logic             enable_q, enable_d;
    logic             started_q, started_d;
    logic             row_odd_q, row_odd_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             ovf_q, ovf_d;

    logic is_pix, is_fs, is_ls, is_le, in_range;
    logic chroma_fire, pass_fire;
    logic [PIXEL_WIDTH-1:0] avg_u, avg_v;

    assign is_pix   = dvi && (dtypei == DTYPE_PXL);
    assign is_fs    = dvi && (dtypei == DTYPE_FRAME_START);
    assign is_ls    = dvi && (dtypei == DTYPE_LINE_START);
    assign is_le    = dvi && (dtypei == DTYPE_LINE_END);
    assign in_range = col_q < COL_MAX;

    // enable_q only goes high at a frame start, so it also implies a frame has started
    assign chroma_fire = is_pix && enable_q && in_range && row_odd_q && col_q[0];
    assign pass_fire   = is_pix && started_q && !enable_q;

    always_comb begin
        enable_d  = enable_q;
        started_d = started_q;
        row_odd_d = row_odd_q;
        col_d     = col_q;
        ovf_d     = ovf_q;
        if (is_fs) begin
            enable_d  = enable;
            started_d = 1'b1;
            row_odd_d = 1'b0;
            col_d     = '0;
            ovf_d     = 1'b0;
        end else begin
            if (is_ls) col_d = '0;
            if (is_le) row_odd_d = !row_odd_q;
            if (is_pix) begin
                if (in_range) col_d = col_q + COL_W'(1);
                else          ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            enable_q  <= 1'b0;
            started_q <= 1'b0;
            row_odd_q <= 1'b0;
            col_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            started_q <= started_d;
            row_odd_q <= row_odd_d;
            col_q     <= col_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef YUV420_CHROMA_DECIMATE_SKIP_EN
    assign avg_u = ui;
    assign avg_v = vi;
`else
    localparam int HSUM_W   = PIXEL_WIDTH + 1;
    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [PIXEL_WIDTH-1:0] u_hold_q, v_hold_q;
    logic [HSUM_W-1:0]      hsum_u, hsum_v, top_u, top_v;
    logic [2*HSUM_W-1:0]    lb_rdata;
    logic                   lb_en;
    logic [HSUM_W:0]        sum_u, sum_v;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            u_hold_q <= '0;
            v_hold_q <= '0;
        end else if (is_pix && enable_q && in_range && !col_q[0]) begin
            u_hold_q <= ui;
            v_hold_q <= vi;
        end
    end

    assign hsum_u = {1'b0, u_hold_q} + {1'b0, ui};
    assign hsum_v = {1'b0, v_hold_q} + {1'b0, vi};

    // Even rows write on odd columns, odd rows read on even columns
    assign lb_en = is_pix && enable_q && in_range && (row_odd_q != col_q[0]);

    yuv420_chroma_decimate_chroma_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (2 * HSUM_W),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .en_i    (lb_en),
        .we_i    (!row_odd_q),
        .addr_i  (col_q[LB_AW:1]),
        .wdata_i ({hsum_u, hsum_v}),
        .rdata_o (lb_rdata)
    );

    assign top_u = lb_rdata[2*HSUM_W-1:HSUM_W];
    assign top_v = lb_rdata[HSUM_W-1:0];
    // Sum of four samples plus 2 never exceeds PIXEL_WIDTH+2 bits
    assign sum_u = {1'b0, top_u} + {1'b0, hsum_u} + (HSUM_W + 1)'(2);
    assign sum_v = {1'b0, top_v} + {1'b0, hsum_v} + (HSUM_W + 1)'(2);
    assign avg_u = PIXEL_WIDTH'(sum_u >> 2);
    assign avg_v = PIXEL_WIDTH'(sum_v >> 2);
`endif

    logic                   s1_dv_q, s1_cv_q, s1_ovf_q;
    logic [DTYPE_WIDTH-1:0] s1_dtype_q;
    logic [DATA_WIDTH-1:0]  s1_meta_q;
    logic [PIXEL_WIDTH-1:0] s1_y_q, s1_u_q, s1_v_q;

    logic                   dv_q, cv_q, ovf_out_q;
    logic [DTYPE_WIDTH-1:0] dtype_q;
    logic [DATA_WIDTH-1:0]  meta_q;
    logic [PIXEL_WIDTH-1:0] y_q, u_q, v_q;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            s1_dv_q    <= 1'b0;
            s1_cv_q    <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s1_dtype_q <= '0;
            s1_meta_q  <= '0;
            s1_y_q     <= '0;
            s1_u_q     <= '0;
            s1_v_q     <= '0;
            dv_q       <= 1'b0;
            cv_q       <= 1'b0;
            ovf_out_q  <= 1'b0;
            dtype_q    <= '0;
            meta_q     <= '0;
            y_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
        end else begin
            s1_dv_q    <= dvi;
            s1_cv_q    <= chroma_fire || pass_fire;
            s1_ovf_q   <= ovf_d;
            s1_dtype_q <= dtypei;
            s1_meta_q  <= meta_datai;
            s1_y_q     <= yi;
            s1_u_q     <= pass_fire ? ui : avg_u;
            s1_v_q     <= pass_fire ? vi : avg_v;
            dv_q       <= s1_dv_q;
            cv_q       <= s1_cv_q;
            ovf_out_q  <= s1_ovf_q;
            dtype_q    <= s1_dtype_q;
            meta_q     <= s1_meta_q;
            y_q        <= s1_y_q;
            if (s1_cv_q) begin
                u_q <= s1_u_q;
                v_q <= s1_v_q;
            end
        end
    end

    assign dvo          = dv_q;
    assign dtypeo       = dtype_q;
    assign meta_datao   = meta_q;
    assign yo           = y_q;
    assign uo           = u_q;
    assign vo           = v_q;
    assign chroma_dvo   = cv_q;
    assign col_overflow = ovf_out_q;

endmodule

// File: tb/tb_yuv420_chroma_decimate.sv
// Directed bench for yuv420_chroma_decimate (PIXEL_WIDTH=8, MAX_COLS=6).
module tb_yuv420_chroma_decimate;
    import yuv420_chroma_decimate_pkg::*;

    localparam int PW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetb, enable, dvi;
    logic [3:0]    dtypei;
    logic [DW-1:0] meta_datai;
    logic [PW-1:0] yi, ui, vi;
    logic          dvo, chroma_dvo, col_overflow;
    logic [3:0]    dtypeo;
    logic [DW-1:0] meta_datao;
    logic [PW-1:0] yo, uo, vo;

    yuv420_chroma_decimate #(
        .PIXEL_WIDTH (PW),
        .DATA_WIDTH  (DW),
        .MAX_COLS    (6)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .enable       (enable),
        .dvi          (dvi),
        .dtypei       (dtypei),
        .meta_datai   (meta_datai),
        .yi           (yi),
        .ui           (ui),
        .vi           (vi),
        .dvo          (dvo),
        .dtypeo       (dtypeo),
        .meta_datao   (meta_datao),
        .yo           (yo),
        .uo           (uo),
        .vo           (vo),
        .chroma_dvo   (chroma_dvo),
        .col_overflow (col_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          dv;
        logic [3:0]    dt;
        logic [DW-1:0] meta;
        logic [PW-1:0] y;
        logic          cdv;
        logic [PW-1:0] u;
        logic [PW-1:0] v;
        logic          ovf;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] meta_n = 16'h0100;
    logic [PW-1:0] last_u = '0;
    logic [PW-1:0] last_v = '0;
    logic          exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        if (e.cdv) begin
            last_u = e.u;
            last_v = e.v;
        end
        chk("dvo", 32'(dvo), 32'(e.dv));
        chk("dtypeo", 32'(dtypeo), 32'(e.dt));
        chk("meta_datao", 32'(meta_datao), 32'(e.meta));
        chk("yo", 32'(yo), 32'(e.y));
        chk("chroma_dvo", 32'(chroma_dvo), 32'(e.cdv));
        chk("uo", 32'(uo), 32'(last_u));
        chk("vo", 32'(vo), 32'(last_v));
        chk("col_overflow", 32'(col_overflow), 32'(exp_ovf_of(e)));
    endtask

    function automatic logic exp_ovf_of(input exp_t e);
        return e.ovf;
    endfunction

    task automatic drive(input logic dv, input logic [3:0] dt, input logic [PW-1:0] y,
                         input logic [PW-1:0] u, input logic [PW-1:0] v,
                         input logic cdv, input logic [PW-1:0] eu, input logic [PW-1:0] ev);
        dvi = dv; dtypei = dt; yi = y; ui = u; vi = v; meta_datai = meta_n;
        exp_q.push_back('{dv, dt, meta_n, y, cdv, eu, ev, exp_ovf});
        meta_n++;
        @(posedge clk); #1;
        if (exp_q.size() == 2) check_entry(exp_q.pop_front());
    endtask

    task automatic pix(input logic [PW-1:0] y, input logic [PW-1:0] u, input logic [PW-1:0] v,
                       input logic cdv, input logic [PW-1:0] eu, input logic [PW-1:0] ev);
        drive(1'b1, DTYPE_PXL, y, u, v, cdv, eu, ev);
    endtask

    task automatic ctl(input logic [3:0] dt);
        drive(1'b1, dt, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic idle();
        drive(1'b0, DTYPE_PXL, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dvo"}, 32'(dvo), 0);
        chk({tag, "_dtypeo"}, 32'(dtypeo), 0);
        chk({tag, "_meta"}, 32'(meta_datao), 0);
        chk({tag, "_yo"}, 32'(yo), 0);
        chk({tag, "_uo"}, 32'(uo), 0);
        chk({tag, "_vo"}, 32'(vo), 0);
        chk({tag, "_cdv"}, 32'(chroma_dvo), 0);
        chk({tag, "_ovf"}, 32'(col_overflow), 0);
    endtask

    // 4x2 frame: odd-row chroma 35/125 then 55/145, with an idle gap before col 1
    task automatic frame_4x2();
        exp_ovf = 1'b0;
        ctl(DTYPE_FRAME_START);
        ctl(DTYPE_LINE_START);
        pix(8'd1, 8'd10, 8'd100, 1'b0, 8'd0, 8'd0);
        pix(8'd2, 8'd20, 8'd110, 1'b0, 8'd0, 8'd0);
        pix(8'd3, 8'd30, 8'd120, 1'b0, 8'd0, 8'd0);
        pix(8'd4, 8'd40, 8'd130, 1'b0, 8'd0, 8'd0);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_LINE_START);
        pix(8'd5, 8'd50, 8'd140, 1'b0, 8'd0, 8'd0);
        idle();
        pix(8'd6, 8'd60, 8'd150, 1'b1, 8'd35, 8'd125);
        pix(8'd7, 8'd70, 8'd160, 1'b0, 8'd0, 8'd0);
        pix(8'd8, 8'd81, 8'd170, 1'b1, 8'd55, 8'd145);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_FRAME_END);
    endtask

    initial begin
        resetb = 1'b0; enable = 1'b1; dvi = 1'b0; dtypei = '0;
        meta_datai = '0; yi = '0; ui = '0; vi = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        resetb = 1'b1;

        // Basic 2x2 averaging
        frame_4x2();

        // Full-scale samples must not overflow
        ctl(DTYPE_FRAME_START);
        ctl(DTYPE_LINE_START);
        pix(8'd11, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
        pix(8'd12, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_LINE_START);
        pix(8'd13, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
        pix(8'd14, 8'd255, 8'd255, 1'b1, 8'd255, 8'd255);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_FRAME_END);

        // Disabled at frame start; mid-frame enable ignored until next frame
        enable = 1'b0;
        ctl(DTYPE_FRAME_START);
        enable = 1'b1;
        ctl(DTYPE_LINE_START);
        pix(8'd21, 8'd1, 8'd5, 1'b1, 8'd1, 8'd5);
        pix(8'd22, 8'd2, 8'd6, 1'b1, 8'd2, 8'd6);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_LINE_START);
        pix(8'd23, 8'd3, 8'd7, 1'b1, 8'd3, 8'd7);
        pix(8'd24, 8'd4, 8'd8, 1'b1, 8'd4, 8'd8);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_FRAME_END);
        ctl(DTYPE_FRAME_START);
        ctl(DTYPE_LINE_START);
        pix(8'd25, 8'd4, 8'd2, 1'b0, 8'd0, 8'd0);
        pix(8'd26, 8'd8, 8'd3, 1'b0, 8'd0, 8'd0);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_LINE_START);
        pix(8'd27, 8'd12, 8'd4, 1'b0, 8'd0, 8'd0);
        pix(8'd28, 8'd16, 8'd5, 1'b1, 8'd10, 8'd4);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_FRAME_END);

        // Odd row length: 5th pixel unpaired
        ctl(DTYPE_FRAME_START);
        for (int r = 0; r < 2; r++) begin
            ctl(DTYPE_LINE_START);
            for (int c = 0; c < 5; c++) begin
                logic [PW-1:0] s;
                logic          fire;
                logic [PW-1:0] e;
                s = PW'((c + 1) * 10);
                fire = (r == 1) && (c == 1 || c == 3);
                e = (c == 1) ? 8'd15 : 8'd35;
                pix(PW'(40 + c), s, s, fire, e, e);
            end
            ctl(DTYPE_LINE_END);
        end
        ctl(DTYPE_FRAME_END);

        // Rows of 8 with MAX_COLS=6: overflow from col 6, three pulses per odd row
        ctl(DTYPE_FRAME_START);
        for (int r = 0; r < 2; r++) begin
            ctl(DTYPE_LINE_START);
            for (int c = 0; c < 8; c++) begin
                logic [PW-1:0] s;
                logic          fire;
                logic [PW-1:0] e;
                s = PW'((c + 1) * 10);
                if (c == 6) exp_ovf = 1'b1;
                fire = (r == 1) && (c == 1 || c == 3 || c == 5);
                e = (c == 1) ? 8'd15 : (c == 3) ? 8'd35 : 8'd55;
                pix(PW'(60 + c), s, s, fire, e, e);
            end
            ctl(DTYPE_LINE_END);
        end
        ctl(DTYPE_FRAME_END);
        exp_ovf = 1'b0;

        // Reset during an odd row, stray pixels, then a clean frame
        frame_4x2();
        ctl(DTYPE_FRAME_START);
        ctl(DTYPE_LINE_START);
        pix(8'd91, 8'd10, 8'd10, 1'b0, 8'd0, 8'd0);
        pix(8'd92, 8'd20, 8'd20, 1'b0, 8'd0, 8'd0);
        ctl(DTYPE_LINE_END);
        ctl(DTYPE_LINE_START);
        pix(8'd93, 8'd30, 8'd30, 1'b0, 8'd0, 8'd0);
        resetb = 1'b0;
        dvi = 1'b1; dtypei = DTYPE_PXL; yi = 8'd94; ui = 8'd40; vi = 8'd40;
        @(posedge clk); #1;
        check_zero("midreset");
        exp_q.delete();
        last_u = '0;
        last_v = '0;
        resetb = 1'b1;
        pix(8'd95, 8'd50, 8'd50, 1'b0, 8'd0, 8'd0);
        pix(8'd96, 8'd60, 8'd60, 1'b0, 8'd0, 8'd0);
        ctl(DTYPE_LINE_END);
        frame_4x2();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/yuv420_chroma_decimate.md
Name: yuv420_chroma_decimate

Overview:
Upstream stage of the YUV 4:2:0 rotate/RAM path, placed before uv_offset in the img_clk pipeline. It converts a 4:4:4 YUV pixel stream, tagged with dtypes, into 4:2:0 form. Y, dtype, meta and dv pass through with fixed latency. U/V are averaged over each 2x2 block and flagged on the bottom-right pixel of the block. A half-width chroma line buffer holds the even-row horizontal sums.

Parameters:
PIXEL_WIDTH, 10, bits per Y/U/V sample
DATA_WIDTH, 16, meta_data width
MAX_COLS, 1920, maximum row length in pixels; must be even

Ports:
clk  in  1  pixel clock (img_clk domain)
resetb  in  1  reset, synchronous, active-low
enable  in  1  decimation enable; sampled only on a frame-start dtype
dvi  in  1  input data valid
dtypei  in  DTYPE_WIDTH  input dtype (shared dtypes.v codes)
meta_datai  in  DATA_WIDTH  input meta data
yi, ui, vi  in  PIXEL_WIDTH each  input samples
dvo  out  1  output valid
dtypeo  out  DTYPE_WIDTH  output dtype
meta_datao  out  DATA_WIDTH  output meta data
yo, uo, vo  out  PIXEL_WIDTH each  output samples
chroma_dvo  out  1  uo/vo hold a new 2x2 average this cycle
col_overflow  out  1  sticky: the current frame had a row longer than MAX_COLS

Behaviour:
- One clock, synchronous active-low resetb. In reset: all outputs 0; row parity even; column counter 0; enable_q 0.
- Latency is exactly 2 cycles for dvo, dtypeo, meta_datao and yo, including non-pixel dtypes. The block never back-pressures.
- Frame start: latch enable_q = enable; row parity = even; clear col_overflow.
- Row start: col = 0. Row end: toggle row parity.
- Pixel (dvi=1 with a pixel dtype): col increments after use.
- Even col: register ui/vi as hold values.
- Odd col: hsum = hold + current, PIXEL_WIDTH+1 bits, unrounded.
- Even row, odd col: write {hsum_u, hsum_v} to line buffer at col>>1.
- Odd row, even col: issue a line buffer read at col>>1; data returns on the next (odd) pixel.
- Odd row, odd col: uo = (top_hsum_u + hsum_u + 2) >> 2, same for vo. Result is PIXEL_WIDTH bits and cannot overflow. chroma_dvo = 1.
- All other cycles: chroma_dvo = 0, and uo/vo hold their last value.
- Line buffer is single-port synchronous. Read and write never occur in the same row, so no collision can happen.
- Odd row length: the trailing unpaired pixel contributes no chroma; it is not written and gives no chroma_dvo.
- Odd frame height: the last even row produces no chroma.
- col >= MAX_COLS: Y passes through; no line buffer access; no chroma_dvo; set col_overflow until the next frame start.
- enable_q = 0: uo = ui, vo = vi with 2-cycle latency; chroma_dvo mirrors pixel dvo; line buffer idle.
- A change of enable mid-frame has no effect until the next frame start.
- resetb asserted mid-frame: state clears at the next clock edge. The stream resumes correctly from the next frame start. Rows after reset and before that frame start give undefined chroma, but chroma_dvo stays 0 until the first frame start.

Optional Feature:
YUV420_CHROMA_DECIMATE_SKIP_EN
- Defined: no averaging and no line buffer instantiated. On odd row, odd col, uo/vo = ui/vi of that pixel with chroma_dvo = 1. Latency is unchanged.
- Undefined: full 2x2 averaging as above.

Decomposition:
- Shared package: dtype codes and DTYPE_WIDTH (existing dtypes.v). No new typedefs; the hsum width PIXEL_WIDTH+1 is a local constant.
- Sub-module chroma_line_buffer: synchronous single-port RAM, MAX_COLS/2 x 2*(PIXEL_WIDTH+1), with 1-cycle read latency. It is omitted under the skip macro.

Test Plan:
- PIXEL_WIDTH=8, 4x2 frame. Even row u=10,20,30,40; odd row u=50,60,70,81 -> chroma_dvo on odd-row cols 1 and 3 only; uo=35 then 55. Every yo equals yi delayed 2 cycles.
- All samples 255 (PIXEL_WIDTH=8), 2x2 frame -> uo=vo=255, no overflow.
- enable=0 at frame start, toggled to 1 mid-frame -> uo=ui, vo=vi for every pixel of that frame; averaging starts from the next frame.
- Row of 5 pixels -> 2 chroma_dvo pulses per odd row; the 5th pixel produces none.
- MAX_COLS=4, row of 6 pixels -> col_overflow=1 from pixel 4 onward; 2 chroma pulses per odd row; col_overflow cleared at the next frame start.
- resetb pulsed low during an odd row -> all outputs 0 the next cycle; the following frame's outputs match the golden model.
